// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between a core and a debug/loader requester
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_valid,
    output logic          c_err,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_valid,
    output logic          d_err,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    state_t        state, state_nx;
    logic          owner;
    logic          last;
    logic          grant_c, grant_d;
    logic [7:0]    cnt;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          at_limit;
    logic          busy, done;

    assign at_limit = cnt == LIMIT;
    assign busy     = state == BUSY;
    assign done     = state == DONE;

    // state register; reset abandons any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next state and grants; on a tie the requester not served last wins (owner/last: 1 = debug)
    always_comb begin
        state_nx = state;
        grant_c  = 1'b0;
        grant_d  = 1'b0;
        case (state)
            IDLE: begin
                grant_c  = !rst && c_req && (!d_req || last);
                grant_d  = !rst && d_req && !grant_c;
                state_nx = (grant_c || grant_d) ? BUSY : IDLE;
            end
            BUSY:    state_nx = (m_ready || at_limit) ? DONE : BUSY;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // request latch, wait counter, response register and round-robin history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= 1'b0;
            last       <= 1'b1;
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_c || grant_d) begin
                        owner     <= grant_d;
                        lat_we    <= grant_d ? d_we : c_we;
                        lat_addr  <= grant_d ? d_addr : c_addr;
                        lat_wdata <= grant_d ? d_wdata : c_wdata;
                        cnt       <= '0;
                    end
                end
                BUSY: begin
                    if (m_ready) begin
                        resp_rdata <= lat_we ? '0 : m_rdata;
                        resp_err   <= 1'b0;
                    end else if (at_limit) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE:    last <= owner;
                default: ;
            endcase
        end
    end

    assign c_gnt   = grant_c;
    assign d_gnt   = grant_d;
    assign m_req   = busy;
    assign m_we    = busy && lat_we;
    assign m_addr  = lat_addr;
    assign m_wdata = lat_wdata;
    assign c_valid = done && !owner;
    assign d_valid = done && owner;
    assign c_err   = c_valid && resp_err;
    assign d_err   = d_valid && resp_err;
    assign c_rdata = resp_rdata;
    assign d_rdata = resp_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed-vector bench for mem_arbiter
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, c_gnt, c_valid, c_err;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic        d_req, d_we, d_gnt, d_valid, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_req, m_we, m_ready;
    logic [31:0] m_addr, m_wdata, m_rdata;
    int          vec = 0;
    int          errs = 0;

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_valid(c_valid), .c_err(c_err), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_err(d_err), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        m_ready = 0; m_rdata = 0;
        do_reset();
        smp();
        vec++; if ({c_gnt, d_gnt, m_req, m_we, c_valid, d_valid, c_err, d_err} !== 8'h00) begin errs++; $display("FAIL reset_ctrl got=%b exp=00000000", {c_gnt, d_gnt, m_req, m_we, c_valid, d_valid, c_err, d_err}); end
        vec++; if ({c_rdata, m_addr, m_wdata} !== 96'h0) begin errs++; $display("FAIL reset_data rdata=%h addr=%h wdata=%h exp 0", c_rdata, m_addr, m_wdata); end
    endtask

    task automatic test_core_read;
        nxt(); c_req = 1; c_we = 0; c_addr = 32'h100; c_wdata = 0; smp();
        vec++; if ({c_gnt, d_gnt} !== 2'b10) begin errs++; $display("FAIL core_read_gnt got=%b exp=10", {c_gnt, d_gnt}); end
        nxt(); c_req = 0; c_addr = 32'hFFFF_0000; smp();
        vec++; if ({m_req, m_we, c_gnt} !== 3'b100 || m_addr !== 32'h100) begin errs++; $display("FAIL core_read_busy1 ctl=%b addr=%h exp=100/00000100", {m_req, m_we, c_gnt}, m_addr); end
        nxt(); smp();
        vec++; if (m_req !== 1'b1 || m_addr !== 32'h100) begin errs++; $display("FAIL core_read_busy2 m_req=%b addr=%h exp=1/00000100", m_req, m_addr); end
        nxt(); m_ready = 1; m_rdata = 32'hDEADBEEF; smp();
        vec++; if ({m_req, c_valid} !== 2'b10) begin errs++; $display("FAIL core_read_busy3 got=%b exp=10", {m_req, c_valid}); end
        nxt(); m_ready = 0; m_rdata = 32'h1111_1111; smp();
        vec++; if ({c_valid, c_err, d_valid, d_err, m_req} !== 5'b10000) begin errs++; $display("FAIL core_read_done got=%b exp=10000", {c_valid, c_err, d_valid, d_err, m_req}); end
        vec++; if (c_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL core_read_rdata got=%h exp=deadbeef", c_rdata); end
        nxt(); smp();
        vec++; if (c_valid !== 1'b0 || c_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL core_read_after valid=%b rdata=%h exp=0/deadbeef", c_valid, c_rdata); end
    endtask

    task automatic test_round_robin;
        do_reset();
        c_req = 1; d_req = 1; c_we = 0; d_we = 0; c_addr = 32'h10; d_addr = 32'h20; m_ready = 1;
        for (int i = 0; i < 4; i++) begin
            logic exp_d;
            exp_d = i[0];
            if (i != 0) nxt();
            m_rdata = 32'hC0DE_0000 + 32'(i);
            smp();
            vec++; if ({c_gnt, d_gnt} !== (exp_d ? 2'b01 : 2'b10)) begin errs++; $display("FAIL rr_gnt%0d got=%b exp_debug=%b", i, {c_gnt, d_gnt}, exp_d); end
            nxt(); smp();
            vec++; if ({c_gnt, d_gnt, m_req} !== 3'b001 || m_addr !== (exp_d ? 32'h20 : 32'h10)) begin errs++; $display("FAIL rr_busy%0d ctl=%b addr=%h", i, {c_gnt, d_gnt, m_req}, m_addr); end
            nxt(); smp();
            vec++; if ({c_valid, d_valid, c_gnt, d_gnt} !== (exp_d ? 4'b0100 : 4'b1000) || c_rdata !== 32'hC0DE_0000 + 32'(i)) begin errs++; $display("FAIL rr_done%0d ctl=%b rdata=%h", i, {c_valid, d_valid, c_gnt, d_gnt}, c_rdata); end
        end
    endtask

    task automatic test_debug_write;
        nxt(); c_req = 0; d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h12345678; m_ready = 0; smp();
        vec++; if ({c_gnt, d_gnt} !== 2'b01) begin errs++; $display("FAIL dbg_wr_gnt got=%b exp=01", {c_gnt, d_gnt}); end
        nxt(); d_req = 0; d_addr = 32'h0; d_wdata = 32'hDEAD_0000; m_ready = 1; m_rdata = 32'hFFFF_FFFF; smp();
        vec++; if ({m_req, m_we} !== 2'b11 || m_addr !== 32'h40 || m_wdata !== 32'h12345678) begin errs++; $display("FAIL dbg_wr_busy ctl=%b addr=%h wdata=%h exp=11/40/12345678", {m_req, m_we}, m_addr, m_wdata); end
        nxt(); m_ready = 0; smp();
        vec++; if ({d_valid, d_err, c_valid, c_err} !== 4'b1000 || d_rdata !== 32'h0) begin errs++; $display("FAIL dbg_wr_done ctl=%b rdata=%h exp=1000/0", {d_valid, d_err, c_valid, c_err}, d_rdata); end
    endtask

    task automatic test_ready_at_limit;
        int n;
        n = 0;
        nxt(); c_req = 1; c_we = 0; c_addr = 32'h300; smp();
        vec++; if (c_gnt !== 1'b1) begin errs++; $display("FAIL limit_gnt got=%b exp=1", c_gnt); end
        for (int j = 0; j < 16; j++) begin
            nxt(); c_req = 0; m_ready = (j == 15); m_rdata = 32'h0BAD_F00D; smp();
            if (m_req === 1'b1) n++;
        end
        vec++; if (n !== 16) begin errs++; $display("FAIL limit_busy_cycles got=%0d exp=16", n); end
        nxt(); m_ready = 0; smp();
        vec++; if ({c_valid, c_err, m_req} !== 3'b100 || c_rdata !== 32'h0BAD_F00D) begin errs++; $display("FAIL limit_done ctl=%b rdata=%h exp=100/0badf00d", {c_valid, c_err, m_req}, c_rdata); end
    endtask

    task automatic test_timeout;
        int n;
        n = 0;
        nxt(); c_req = 1; c_addr = 32'h200; smp();
        vec++; if (c_gnt !== 1'b1) begin errs++; $display("FAIL to_gnt got=%b exp=1", c_gnt); end
        for (int j = 0; j < 40; j++) begin
            nxt(); c_req = 0; m_ready = 0; smp();
            if (m_req !== 1'b1) break;
            n++;
        end
        vec++; if (n !== 16) begin errs++; $display("FAIL to_busy_cycles got=%0d exp=16", n); end
        vec++; if ({c_valid, c_err, d_valid} !== 3'b110 || c_rdata !== 32'h0) begin errs++; $display("FAIL to_done ctl=%b rdata=%h exp=110/0", {c_valid, c_err, d_valid}, c_rdata); end
        nxt(); c_req = 1; c_addr = 32'h204; smp();
        vec++; if (c_gnt !== 1'b1) begin errs++; $display("FAIL to_next_gnt got=%b exp=1", c_gnt); end
        nxt(); c_req = 0; m_ready = 1; m_rdata = 32'hA5A5_A5A5; smp();
        vec++; if (m_req !== 1'b1 || m_addr !== 32'h204) begin errs++; $display("FAIL to_next_busy m_req=%b addr=%h exp=1/204", m_req, m_addr); end
        nxt(); m_ready = 0; smp();
        vec++; if ({c_valid, c_err} !== 2'b10 || c_rdata !== 32'hA5A5_A5A5) begin errs++; $display("FAIL to_next_done ctl=%b rdata=%h exp=10/a5a5a5a5", {c_valid, c_err}, c_rdata); end
    endtask

    task automatic test_reset_mid_busy;
        nxt(); c_req = 1; c_we = 0; c_addr = 32'h400; m_ready = 0; smp();
        vec++; if (c_gnt !== 1'b1) begin errs++; $display("FAIL rstb_gnt got=%b exp=1", c_gnt); end
        nxt(); smp();
        vec++; if (m_req !== 1'b1) begin errs++; $display("FAIL rstb_busy m_req=%b exp=1", m_req); end
        #1 rst = 1'b1;
        #1;
        vec++; if ({m_req, c_valid, d_valid} !== 3'b000) begin errs++; $display("FAIL rstb_async got=%b exp=000", {m_req, c_valid, d_valid}); end
        @(posedge clk); smp();
        vec++; if ({m_req, c_valid, c_err} !== 3'b000 || c_rdata !== 32'h0) begin errs++; $display("FAIL rstb_held ctl=%b rdata=%h exp=000/0", {m_req, c_valid, c_err}, c_rdata); end
        @(posedge clk); #1; rst = 1'b0; smp();
        vec++; if ({c_gnt, d_gnt} !== 2'b10) begin errs++; $display("FAIL rstb_first_gnt got=%b exp=10", {c_gnt, d_gnt}); end
        nxt(); m_ready = 1; m_rdata = 32'h600D_600D; smp();
        vec++; if (m_req !== 1'b1 || m_addr !== 32'h400) begin errs++; $display("FAIL rstb_rebusy m_req=%b addr=%h exp=1/400", m_req, m_addr); end
        nxt(); c_req = 0; m_ready = 0; smp();
        vec++; if ({c_valid, c_err} !== 2'b10 || c_rdata !== 32'h600D_600D) begin errs++; $display("FAIL rstb_done ctl=%b rdata=%h exp=10/600d600d", {c_valid, c_err}, c_rdata); end
    endtask

    initial begin
        test_reset();
        test_core_read();
        test_round_robin();
        test_debug_write();
        test_ready_at_limit();
        test_timeout();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum BUSY cycles waiting for m_ready (legal range 2..255).
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports c_req/c_we (in, 1), c_addr (in, AW) and c_wdata (in, DW), forming the core request.
REQ-007 SHALL have ports c_gnt/c_valid/c_err (out, 1) and c_rdata (out, DW), forming the core response.
REQ-008 SHALL have ports d_req/d_we/d_addr/d_wdata and d_gnt/d_valid/d_err/d_rdata for the debug/loader requester, with widths as for core.
REQ-009 SHALL have memory ports m_req/m_we (out, 1), m_addr (out, AW), m_wdata (out, DW), m_rdata (in, DW) and m_ready (in, 1).

Function
REQ-010 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-011 IDLE: with one requester asserting req, SHALL assert its gnt combinationally that cycle, latch we/addr/wdata and owner at the edge, and go to BUSY.
REQ-012 IDLE with both req high SHALL grant the requester not served last (round-robin); only one gnt may ever be high.
REQ-013 IDLE with no req SHALL remain in IDLE with all gnt low.
REQ-014 Requester SHALL hold req and fields stable until gnt; req or field changes after the grant edge SHALL NOT affect the transaction.
REQ-015 BUSY: m_req=1; m_we/m_addr/m_wdata SHALL drive latched values, constant for the whole BUSY phase.
REQ-016 BUSY with m_ready=1 at an edge SHALL capture m_rdata (reads) or 0 (writes) into the response register, clear err, and go to DONE.
REQ-017 BUSY SHALL increment an 8-bit wait counter, cleared on entry; if m_ready=0 at count TIMEOUT-1, SHALL go to DONE with rdata=0 and err=1.
REQ-018 m_ready and timeout in the same cycle: m_ready SHALL win (no error).
REQ-019 DONE: owner's valid=1 for exactly one cycle with rdata/err; other requester's valid/err=0; next state IDLE.
REQ-020 DONE SHALL update last-served to the owner; no grant in DONE (gnt only in IDLE).
REQ-021 Latency: grant cycle N, m_req from N+1, m_ready at N+k (k>=1) -> valid at N+k+1; back-to-back grants at best every 3 cycles.
REQ-022 m_req, gnt, valid and err SHALL be 0 outside the states above; rdata holds last value except as set in REQ-016/017.
REQ-023 m_ready outside BUSY SHALL be ignored.

Reset
REQ-024 rst=1 SHALL force IDLE, last-served=debug (core wins first tie), wait counter=0, response rdata=0, err=0, latched fields=0.
REQ-025 rst during BUSY/DONE SHALL drop m_req and valid immediately (asynchronous) and abandon the transaction without a response.
REQ-026 First grant SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-027 Core read, addr=0x100, m_ready 2 cycles after m_req, m_rdata=0xDEADBEEF -> c_valid one cycle, c_rdata=0xDEADBEEF, c_err=0, d_* quiet.
REQ-028 Core and debug both request from reset -> core granted first, debug next; repeated contention alternates C,D,C,D.
REQ-029 Debug write addr=0x40 wdata=0x12345678, m_ready=1 on first BUSY cycle -> m_we=1, fields stable, d_valid 2 cycles after d_gnt, d_rdata=0.
REQ-030 TIMEOUT=16, m_ready held 0 -> m_req high exactly 16 cycles, then c_valid=1, c_err=1, c_rdata=0; next request served normally.
REQ-031 m_ready asserted in the final counted BUSY cycle -> normal response, err=0.
REQ-032 rst asserted mid-BUSY -> m_req falls without a clock edge, no valid pulse; after release, pending core req granted in the first cycle.
